// File: rtl/prog_sequencer_if.sv
// Bus between the program sequencer and its environment (instruction ROM, processor, control).
// The master modport is the sequencer side.
interface prog_sequencer_if #(
  parameter int unsigned AW = 5
);
  logic          Start;
  logic          Halt;
  logic [AW-1:0] End_addr;
  logic [15:0]   Mem_q;
  logic          Done;
  logic [AW-1:0] Mem_addr;
  logic [15:0]   DIN;
  logic          Run;
  logic          Busy;
  logic          Finished;
  logic          Error;
  logic [AW-1:0] PC;
  logic [7:0]    Instr_count;

  modport master (
    input  Start, Halt, End_addr, Mem_q, Done,
    output Mem_addr, DIN, Run, Busy, Finished, Error, PC, Instr_count
  );

  modport slave (
    output Start, Halt, End_addr, Mem_q, Done,
    input  Mem_addr, DIN, Run, Busy, Finished, Error, PC, Instr_count
  );
endinterface

// File: rtl/prog_sequencer.sv
// Autonomous instruction feeder: fetches words from a synchronous ROM and drives them onto a
// 16-bit bus processor with a Run pulse, supplying the mvi immediate and waiting for Done.
module prog_sequencer #(
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input logic              Clock,
  input logic              Resetn,
  prog_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StIssue, StOperand, StWait, StError
  } state_e;

  localparam logic [2:0] OpMvi      = 3'b001;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [15:0]   instr_q, instr_d;
  logic [15:0]   operand_q, operand_d;
  logic          finished_q, finished_d;

  logic [AW-1:0] words, pc_next, pc_last;
  logic          end_hit;

  // Retire bookkeeping; only meaningful in StOperand/StWait.
  always_comb begin
    words   = (state_q == StOperand) ? AW'(2) : AW'(1);
    pc_next = pc_q + words;
    pc_last = pc_q + words - AW'(1);
    end_hit = (bus.End_addr == pc_q) || (bus.End_addr == pc_last);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    instr_d    = instr_q;
    operand_d  = operand_q;
    finished_d = 1'b0;
    case (state_q)
      StIdle, StError: begin
        if (bus.Start) begin
          pc_d    = '0;
          count_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        instr_d = bus.Mem_q;
        state_d = StIssue;
      end
      StIssue: begin
        // Mem_q now holds the word after the instruction (prefetched in StLatch).
        operand_d = bus.Mem_q;
        tmo_d     = '0;
        state_d   = (instr_q[15:13] == OpMvi) ? StOperand : StWait;
      end
      StOperand, StWait: begin
        if (bus.Done) begin
          pc_d    = pc_next;
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          if (end_hit) begin
            finished_d = 1'b1;
            state_d    = StIdle;
          end else if (bus.Halt) begin
            state_d = StIdle;
          end else if (pc_next == '0) begin
            finished_d = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d = StFetch;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d >= TimeoutCnt) begin
            state_d = StError;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      instr_q    <= '0;
      operand_q  <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      instr_q    <= instr_d;
      operand_q  <= operand_d;
      finished_q <= finished_d;
    end
  end

  // Processor-facing outputs depend on registered state only.
  always_comb begin
    bus.Run         = (state_q == StIssue);
    bus.DIN         = (state_q == StOperand) ? operand_q : instr_q;
    bus.Busy        = !(state_q inside {StIdle, StError});
    bus.Error       = (state_q == StError);
    bus.Finished    = finished_q;
    bus.PC          = pc_q;
    bus.Instr_count = count_q;
    bus.Mem_addr    = (state_q == StLatch) ? pc_q + AW'(1) : pc_q;
  end

endmodule
